// File: rtl/memory.sv
// Memory-access stage of the RV64 5-stage pipeline: issues data-bus requests,
// stalls upstream until the handshake completes, aligns load data into dataM.
package memory_pkg;
   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic [4:0]  dst;
      logic [63:0] result;
      logic        memread;
      logic        memwrite;
      logic [2:0]  msize;
      logic [63:0] wdata;
   } execute_data_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic [4:0]  dst;
      logic [63:0] regdata;
      logic        misalign;
   } memory_data_t;
endpackage

module memory
   import memory_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  execute_data_t dataE,
   output logic          stall,
   output dbus_req_t     dreq,
   input  dbus_resp_t    dresp,
   output memory_data_t  dataM
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   memory_data_t r_dataM_p1;
   memory_data_t w_dataM_p0;
   logic         w_memop;
   logic         w_aligned;
   logic         w_issue;
   logic [2:0]   w_off;
   logic [5:0]   w_bitoff;
   logic [63:0]  w_ldraw;

   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
      logic ok;
      case (size)
         2'd0:    ok = 1'b1;
         2'd1:    ok = ~off[0];
         2'd2:    ok = (off[1:0] == 2'b00);
         default: ok = (off == 3'b000);
      endcase
      return ok;
   endfunction

   function automatic logic [7:0] strobe_of(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] base;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   function automatic logic [63:0] load_ext(input logic [2:0] msize, input logic [63:0] raw);
      logic [63:0] res;
      case (msize)
         3'b000:  res = {{56{raw[7]}},  raw[7:0]};
         3'b100:  res = {56'd0,         raw[7:0]};
         3'b001:  res = {{48{raw[15]}}, raw[15:0]};
         3'b101:  res = {48'd0,         raw[15:0]};
         3'b010:  res = {{32{raw[31]}}, raw[31:0]};
         3'b110:  res = {32'd0,         raw[31:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   assign w_off     = dataE.result[2:0];
   assign w_bitoff  = {w_off, 3'b000};
   assign w_memop   = dataE.valid & (dataE.memread | dataE.memwrite);
   assign w_aligned = is_aligned(dataE.msize[1:0], w_off);
   // Gating with reset keeps the bus and stall quiet while reset is held.
   assign w_issue   = reset & w_memop & w_aligned;
   assign stall     = w_issue & ~dresp.data_ok;
   assign w_ldraw   = dresp.data >> w_bitoff;

   always_comb begin
      dreq        = '0;
      dreq.valid  = w_issue;
      dreq.addr   = dataE.result;
      dreq.size   = {1'b0, dataE.msize[1:0]};
      dreq.strobe = dataE.memwrite ? strobe_of(dataE.msize[1:0], w_off) : 8'h00;
      dreq.data   = dataE.wdata << w_bitoff;
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (stall)  w_state_nxt = S_WAIT;
         S_WAIT:  if (!stall) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // p0 -> p1: select completion, bubble, misalign trap or ALU pass-through
   always_comb begin
      w_dataM_p0 = '0;
      if (w_issue) begin
         if (dresp.data_ok) begin
            w_dataM_p0.valid    = 1'b1;
            w_dataM_p0.regwrite = dataE.memread & dataE.regwrite;
            w_dataM_p0.dst      = dataE.dst;
            w_dataM_p0.regdata  = dataE.memread ? load_ext(dataE.msize, w_ldraw) : 64'd0;
         end
      end else if (w_memop) begin
         w_dataM_p0.valid    = 1'b1;
         w_dataM_p0.dst      = dataE.dst;
         w_dataM_p0.misalign = 1'b1;
      end else begin
         w_dataM_p0.valid    = dataE.valid;
         w_dataM_p0.regwrite = dataE.regwrite;
         w_dataM_p0.dst      = dataE.dst;
         w_dataM_p0.regdata  = dataE.result;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) r_dataM_p1 <= '0;
      else        r_dataM_p1 <= w_dataM_p0;
   end

   assign dataM = r_dataM_p1;

endmodule

// File: tb/tb_memory.sv
// Randomized self-checking bench for the memory stage against a byte-level
// reference model of requests, strobes and load extension.
module tb_memory;
   import memory_pkg::*;

   logic          clk;
   logic          reset;
   execute_data_t dataE;
   logic          stall;
   dbus_req_t     dreq;
   dbus_resp_t    dresp;
   memory_data_t  dataM;

   int n_tests = 0;
   int n_fail  = 0;

   memory dut (
      .clk   (clk),
      .reset (reset),
      .dataE (dataE),
      .stall (stall),
      .dreq  (dreq),
      .dresp (dresp),
      .dataM (dataM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] ms);
      return 1 << ms[1:0];
   endfunction

   function automatic logic m_aligned(input logic [63:0] a, input logic [2:0] ms);
      return (a % nbytes(ms)) == 0;
   endfunction

   function automatic logic [7:0] m_strobe(input int off, input logic [2:0] ms);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < nbytes(ms); i++) s[off + i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] d, input int off, input logic [2:0] ms);
      logic [63:0] v = 64'd0;
      int n = nbytes(ms);
      for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
      if (!ms[2] && n < 8 && v[8*n-1])
         for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic chk_dataM(input string tag, input logic v, input logic rw, input logic [4:0] dst,
                            input logic [63:0] rd, input logic mis);
      chk({tag, ".ctl"}, {57'd0, dataM.valid, dataM.regwrite, dataM.dst},
          {57'd0, v, rw, dst});
      chk({tag, ".regdata"}, dataM.regdata, rd);
      chk({tag, ".misalign"}, {63'd0, dataM.misalign}, {63'd0, mis});
   endtask

   // Entered and left 1 time unit after a rising edge.
   task automatic run_op(input string tag, input execute_data_t e, input int lat, input logic [63:0] rdata);
      logic       memop, issue;
      int         off;
      logic [7:0] strb;
      memop = e.valid & (e.memread | e.memwrite);
      issue = memop & m_aligned(e.result, e.msize);
      off   = int'(e.result % 8);
      strb  = e.memwrite ? m_strobe(off, e.msize) : 8'h00;
      dataE = e;
      if (issue) begin
         for (int k = 0; k <= lat; k++) begin
            dresp.data_ok = (k == lat);
            dresp.data    = (k == lat) ? rdata : {$urandom, $urandom};
            @(negedge clk);
            chk({tag, ".dreq.valid"}, {63'd0, dreq.valid}, 64'd1);
            chk({tag, ".stall"}, {63'd0, stall}, {63'd0, (k < lat)});
            chk({tag, ".addr"}, dreq.addr, e.result);
            chk({tag, ".size"}, {61'd0, dreq.size}, {61'd0, 1'b0, e.msize[1:0]});
            chk({tag, ".strobe"}, {56'd0, dreq.strobe}, {56'd0, strb});
            if (e.memwrite) chk({tag, ".wdata"}, dreq.data, e.wdata << (8 * off));
            @(posedge clk); #1;
            if (k < lat)
               chk({tag, ".bubble"}, {62'd0, dataM.valid, dataM.regwrite}, 64'd0);
            else
               chk_dataM(tag, 1'b1, e.memread & e.regwrite, e.dst,
                         e.memread ? m_load(rdata, off, e.msize) : 64'd0, 1'b0);
         end
      end else begin
         dresp.data_ok = 1'($urandom);
         dresp.data    = {$urandom, $urandom};
         @(negedge clk);
         chk({tag, ".dreq.valid"}, {63'd0, dreq.valid}, 64'd0);
         chk({tag, ".stall"}, {63'd0, stall}, 64'd0);
         @(posedge clk); #1;
         if (memop) chk_dataM(tag, 1'b1, 1'b0, e.dst, 64'd0, 1'b1);
         else       chk_dataM(tag, e.valid, e.regwrite, e.dst, e.result, 1'b0);
      end
      dresp.data_ok = 1'b0;
   endtask

   function automatic execute_data_t mk(input logic rd, input logic wr, input logic [2:0] ms,
                                        input logic [63:0] a, input logic [63:0] wd,
                                        input logic [4:0] dst);
      execute_data_t e;
      e.valid = 1'b1; e.regwrite = ~wr; e.dst = dst; e.result = a;
      e.memread = rd; e.memwrite = wr; e.msize = ms; e.wdata = wd;
      return e;
   endfunction

   initial begin
      execute_data_t e;
      logic [2:0] ms;
      int kind;
      reset = 1'b0;
      dresp = '0;
      dataE = mk(1'b1, 1'b0, 3'b011, 64'h100, 64'd0, 5'd7);
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
         dresp.data_ok = 1'b1;
         @(negedge clk);
         chk("rst.dreq.valid", {63'd0, dreq.valid}, 64'd0);
         chk("rst.stall", {63'd0, stall}, 64'd0);
         chk("rst.dataM", {dataM.regdata ^ 64'(dataM.dst)}, 64'd0);
         chk("rst.dataM.ctl", {61'd0, dataM.valid, dataM.regwrite, dataM.misalign}, 64'd0);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      run_op("rst_release_ld", dataE, 1, 64'h0123_4567_89AB_CDEF);

      e = mk(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 5'd5);
      run_op("alu", e, 0, 64'd0);
      run_op("lb_lat2", mk(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd9), 2, 64'h0000_0000_8000_0000);
      run_op("sh_zw", mk(1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 5'd3), 0, 64'd0);
      chk("sh_zw.const", dut.dreq.data, 64'hBEEF_0000_0000_0000);
      run_op("lw_mis", mk(1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 5'd4), 0, 64'd0);

      // LD left outstanding, reset mid-wait, then ALU op with a stray data_ok
      e = mk(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd11);
      dataE = e;
      for (int k = 0; k < 2; k++) begin
         dresp.data_ok = 1'b0;
         @(negedge clk);
         chk("wrst.stall", {63'd0, stall}, 64'd1);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(negedge clk);
      chk("wrst.dreq.valid", {63'd0, dreq.valid}, 64'd0);
      chk("wrst.stall0", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      chk_dataM("wrst.dataM", 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
      reset = 1'b1;
      e = mk(1'b0, 1'b0, 3'b000, 64'hCAFE, 64'd0, 5'd12);
      dataE = e;
      dresp.data_ok = 1'b1;
      @(negedge clk);
      chk("wrst.alu.stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      chk_dataM("wrst.alu", 1'b1, 1'b1, 5'd12, 64'hCAFE, 1'b0);
      run_op("post_rst_ld", mk(1'b1, 1'b0, 3'b110, 64'h5004, 64'd0, 5'd13), 0, 64'hF000_0000_FFFF_FFFF);

      for (int t = 0; t < 300; t++) begin
         kind = $urandom_range(0, 2);
         e.result = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) e.result[2:0] = 3'($urandom_range(0, 7) & ~((1 << $urandom_range(0, 3)) - 1));
         if (kind == 1) begin
            ms = 3'($urandom_range(0, 6));
            e = mk(1'b1, 1'b0, ms, e.result, 64'd0, 5'($urandom));
         end else if (kind == 2) begin
            ms = 3'($urandom_range(0, 3));
            e = mk(1'b0, 1'b1, ms, e.result, {$urandom, $urandom}, 5'($urandom));
         end else begin
            e = mk(1'b0, 1'b0, 3'($urandom), e.result, {$urandom, $urandom}, 5'($urandom));
            e.regwrite = 1'($urandom);
            e.valid    = ($urandom_range(0, 7) != 0);
         end
         run_op("rand", e, $urandom_range(0, 3), {$urandom, $urandom});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
